// File: rtl/cart_loader_if.sv
// Loader (ioctl) download stream plus cartridge memory write port used by cart_loader.
interface cart_loader_if #(
  parameter int ADDR_W = 20
);
  logic              ioctl_download;
  logic              ioctl_wr;
  logic [24:0]       ioctl_addr;
  logic [7:0]        ioctl_dout;
  logic [7:0]        ioctl_index;
  logic              ioctl_wait;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_data;
  logic              mem_we;
  logic              mem_ack;

  modport master (
    output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_index, mem_ack,
    input  ioctl_wait, mem_addr, mem_data, mem_we
  );

  modport slave (
    input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_index, mem_ack,
    output ioctl_wait, mem_addr, mem_data, mem_we
  );
endinterface

// File: rtl/cart_loader.sv
// Cartridge image loader: forwards download bytes to memory, tracks pages, SG-1000 and extra-RAM flags.
// Optional byte checksum output cart_sum when CART_LOADER_CHECKSUM_EN is defined.
module cart_loader #(
  parameter int ADDR_W = 20
) (
  input  logic              clk_sys,
  input  logic              reset,
  cart_loader_if.slave      bus,
  output logic [ADDR_W-15:0] cart_pages,
  output logic              sg1000,
  output logic              extram,
  output logic              loading,
  output logic              load_done,
  output logic              overflow
`ifdef CART_LOADER_CHECKSUM_EN
  ,
  output logic [15:0]       cart_sum
`endif
);

  localparam int PAGE_W = ADDR_W - 14;
  localparam logic [ADDR_W-1:0] EXT_FIRST = ADDR_W'(32'h2000);
  localparam logic [ADDR_W-1:0] EXT_LAST  = ADDR_W'(32'h3FFF);

  typedef enum logic [1:0] {IDLE, WRITE, WAIT_ACK, FINISH} state_t;

  state_t            state_reg, state_next;
  logic              dl_prev_reg;
  logic              fall_pending_reg, fall_pending_next;
  logic [ADDR_W-1:0] mem_addr_reg, mem_addr_next;
  logic [7:0]        mem_data_reg, mem_data_next;
  logic [PAGE_W-1:0] cart_pages_reg, cart_pages_next;
  logic              sg1000_reg, sg1000_next;
  logic              extram_reg, extram_next;
  logic              loading_reg, loading_next;
  logic              overflow_reg, overflow_next;

  logic              dl_fall;
  logic              finish_due;
  logic              in_range;
  logic              wr_req;
  logic              accept;
  logic              drop;
  logic              dout_ff;
  logic [ADDR_W-1:0] addr_low;
  logic [PAGE_W-1:0] addr_page;
  logic              unused_index_bits;

  assign dl_fall    = dl_prev_reg & ~bus.ioctl_download;
  // A falling edge seen while a byte is in flight is remembered until the write retires.
  assign finish_due = fall_pending_reg | dl_fall;
  assign in_range   = (bus.ioctl_addr >> ADDR_W) == 25'd0;
  assign wr_req     = (state_reg == IDLE) & ~finish_due & bus.ioctl_download & bus.ioctl_wr;
  assign accept     = wr_req & in_range;
  assign drop       = wr_req & ~in_range;
  assign addr_low   = bus.ioctl_addr[ADDR_W-1:0];
  assign addr_page  = addr_low[ADDR_W-1:14];
  assign dout_ff    = (bus.ioctl_dout == 8'hFF);
  assign unused_index_bits = &bus.ioctl_index[7:5];

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_reg        <= IDLE;
      dl_prev_reg      <= 1'b0;
      fall_pending_reg <= 1'b0;
      mem_addr_reg     <= '0;
      mem_data_reg     <= '0;
      cart_pages_reg   <= '0;
      sg1000_reg       <= 1'b0;
      extram_reg       <= 1'b0;
      loading_reg      <= 1'b0;
      overflow_reg     <= 1'b0;
    end else begin
      state_reg        <= state_next;
      dl_prev_reg      <= bus.ioctl_download;
      fall_pending_reg <= fall_pending_next;
      mem_addr_reg     <= mem_addr_next;
      mem_data_reg     <= mem_data_next;
      cart_pages_reg   <= cart_pages_next;
      sg1000_reg       <= sg1000_next;
      extram_reg       <= extram_next;
      loading_reg      <= loading_next;
      overflow_reg     <= overflow_next;
    end
  end

  always_comb begin
    state_next        = state_reg;
    fall_pending_next = fall_pending_reg;
    mem_addr_next     = mem_addr_reg;
    mem_data_next     = mem_data_reg;
    cart_pages_next   = cart_pages_reg;
    sg1000_next       = sg1000_reg;
    extram_next       = extram_reg;
    loading_next      = loading_reg;
    overflow_next     = overflow_reg;

    case (state_reg)
      IDLE: begin
        if (finish_due) state_next = FINISH;
        else if (accept) state_next = WRITE;
      end
      WRITE: begin
        if (bus.mem_ack) state_next = finish_due ? FINISH : IDLE;
        else state_next = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (bus.mem_ack) state_next = finish_due ? FINISH : IDLE;
      end
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase

    if (accept) begin
      mem_addr_next = addr_low;
      mem_data_next = bus.ioctl_dout;
      loading_next  = 1'b1;
      // Address 0 marks the start of a fresh image.
      if (addr_low == '0) begin
        cart_pages_next = '0;
        overflow_next   = 1'b0;
        extram_next     = 1'b0;
        sg1000_next     = (bus.ioctl_index[4:0] == 5'd2);
      end else begin
        if (addr_page > cart_pages_reg) cart_pages_next = addr_page;
        if (addr_low == EXT_FIRST) extram_next = sg1000_reg & dout_ff;
        else if (addr_low > EXT_FIRST && addr_low <= EXT_LAST) extram_next = extram_reg & dout_ff;
      end
    end

    if (drop) overflow_next = 1'b1;

    if (state_next == FINISH) begin
      fall_pending_next = 1'b0;
      loading_next      = 1'b0;
    end else if (dl_fall) begin
      fall_pending_next = 1'b1;
    end
  end

`ifdef CART_LOADER_CHECKSUM_EN
  logic [15:0] sum_reg, sum_next;

  always_comb begin
    sum_next = sum_reg;
    if (accept) sum_next = ((addr_low == '0) ? 16'd0 : sum_reg) + {8'd0, bus.ioctl_dout};
  end

  always_ff @(posedge clk_sys) begin
    if (reset) sum_reg <= '0;
    else       sum_reg <= sum_next;
  end

  assign cart_sum = sum_reg;
`endif

  assign bus.mem_we     = (state_reg == WRITE) | (state_reg == WAIT_ACK);
  assign bus.ioctl_wait = (state_reg == WRITE) | (state_reg == WAIT_ACK);
  assign bus.mem_addr   = mem_addr_reg;
  assign bus.mem_data   = mem_data_reg;
  assign load_done      = (state_reg == FINISH);
  assign cart_pages     = cart_pages_reg;
  assign sg1000         = sg1000_reg;
  assign extram         = extram_reg;
  assign loading        = loading_reg;
  assign overflow       = overflow_reg;

endmodule

// File: tb/tb_cart_loader.sv
// Directed bench for cart_loader: handshake timing, flags, page tracking, overflow, reset and end-of-load.
module tb_cart_loader;
  localparam int ADDR_W = 20;

  logic clk_sys = 1'b0;
  logic reset;
  always #5 clk_sys = ~clk_sys;

  cart_loader_if #(.ADDR_W(ADDR_W)) bus ();

  logic [ADDR_W-15:0] cart_pages;
  logic sg1000, extram, loading, load_done, overflow;
`ifdef CART_LOADER_CHECKSUM_EN
  logic [15:0] cart_sum;
`endif

  cart_loader #(.ADDR_W(ADDR_W)) dut (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .bus        (bus),
    .cart_pages (cart_pages),
    .sg1000     (sg1000),
    .extram     (extram),
    .loading    (loading),
    .load_done  (load_done),
    .overflow   (overflow)
`ifdef CART_LOADER_CHECKSUM_EN
    ,
    .cart_sum   (cart_sum)
`endif
  );

  int n_checks = 0;
  int n_fail = 0;
  int done_cnt = 0;
  int we_cnt = 0;
  logic we_prev = 1'b0;

  // Event counters sampled just after each rising edge.
  always @(posedge clk_sys) begin
    #1;
    if (load_done === 1'b1) done_cnt++;
    if (bus.mem_we === 1'b1 && we_prev !== 1'b1) we_cnt++;
    we_prev = bus.mem_we;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // Called at a falling edge; returns at a falling edge after the ack has been consumed.
  task automatic write_byte(input logic [24:0] addr, input logic [7:0] data, input int delay,
                            output logic we_seen, output logic wait_seen,
                            output logic [ADDR_W-1:0] addr_seen, output logic [7:0] data_seen,
                            output logic held_ok, output logic we_after);
    bus.ioctl_download = 1'b1;
    bus.ioctl_addr = addr;
    bus.ioctl_dout = data;
    bus.ioctl_wr = 1'b1;
    @(negedge clk_sys);
    bus.ioctl_wr = 1'b0;
    we_seen = bus.mem_we;
    wait_seen = bus.ioctl_wait;
    addr_seen = bus.mem_addr;
    data_seen = bus.mem_data;
    held_ok = 1'b1;
    for (int i = 0; i < delay; i++) begin
      @(negedge clk_sys);
      if (bus.mem_we !== 1'b1 || bus.ioctl_wait !== 1'b1 ||
          bus.mem_addr !== addr_seen || bus.mem_data !== data_seen) held_ok = 1'b0;
    end
    bus.mem_ack = 1'b1;
    @(negedge clk_sys);
    bus.mem_ack = 1'b0;
    we_after = bus.mem_we;
  endtask

  task automatic quick_write(input logic [24:0] addr, input logic [7:0] data);
    logic a, b, c, d;
    logic [ADDR_W-1:0] x;
    logic [7:0] y;
    write_byte(addr, data, 0, a, b, x, y, c, d);
  endtask

  task automatic end_download(output logic seen, output int cycles);
    bus.ioctl_download = 1'b0;
    seen = 1'b0;
    cycles = 0;
    while (!seen && cycles < 10) begin
      @(negedge clk_sys);
      cycles++;
      if (load_done === 1'b1) seen = 1'b1;
    end
    repeat (2) @(negedge clk_sys);
  endtask

  task automatic test_reset();
    bus.ioctl_download = 1'b0; bus.ioctl_wr = 1'b0; bus.ioctl_addr = '0;
    bus.ioctl_dout = '0; bus.ioctl_index = '0; bus.mem_ack = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clk_sys);
    n_checks++;
    if (bus.mem_we !== 1'b0 || bus.ioctl_wait !== 1'b0 || load_done !== 1'b0 || loading !== 1'b0)
      begin n_fail++; $display("FAIL reset_ctrl: we=%b wait=%b done=%b loading=%b, required all 0",
                               bus.mem_we, bus.ioctl_wait, load_done, loading); end
    n_checks++;
    if (overflow !== 1'b0 || sg1000 !== 1'b0 || extram !== 1'b0 || cart_pages !== '0)
      begin n_fail++; $display("FAIL reset_flags: ovf=%b sg=%b ext=%b pages=%0d, required 0",
                               overflow, sg1000, extram, cart_pages); end
    reset = 1'b0;
    @(negedge clk_sys);
    n_checks++;
    if (bus.mem_addr !== '0 || bus.mem_data !== '0 || bus.mem_we !== 1'b0)
      begin n_fail++; $display("FAIL reset_mem: addr=%h data=%h we=%b, required 0/0/0",
                               bus.mem_addr, bus.mem_data, bus.mem_we); end
  endtask

  task automatic test_empty_download();
    int d0, cyc;
    logic seen;
    d0 = done_cnt;
    bus.ioctl_download = 1'b1;
    repeat (3) @(negedge clk_sys);
    end_download(seen, cyc);
    n_checks++;
    if (!seen || cyc != 1) begin n_fail++;
      $display("FAIL empty_done: seen=%b after %0d cycles, required pulse after 1", seen, cyc); end
    n_checks++;
    if (done_cnt - d0 != 1 || loading !== 1'b0) begin n_fail++;
      $display("FAIL empty_count: pulses=%0d loading=%b, required 1 and 0", done_cnt - d0, loading); end
    bus.ioctl_addr = 25'h40; bus.ioctl_dout = 8'h99; bus.ioctl_wr = 1'b1;
    @(negedge clk_sys);
    bus.ioctl_wr = 1'b0;
    n_checks++;
    if (bus.mem_we !== 1'b0 || bus.ioctl_wait !== 1'b0) begin n_fail++;
      $display("FAIL no_download_wr: we=%b wait=%b, required 0/0", bus.mem_we, bus.ioctl_wait); end
    @(negedge clk_sys);
  endtask

  task automatic test_basic_load();
    logic we_s, wait_s, held, we_a, seen;
    logic [ADDR_W-1:0] a_s;
    logic [7:0] d_s, exp_d;
    logic [31:0] vals;
    int d0, cyc;
    vals = 32'hC33C5AA5;
    d0 = done_cnt;
    bus.ioctl_index = 8'h00;
    for (int i = 0; i < 4; i++) begin
      exp_d = vals[8*i +: 8];
      write_byte(25'(i), exp_d, 2, we_s, wait_s, a_s, d_s, held, we_a);
      n_checks++;
      if (we_s !== 1'b1 || wait_s !== 1'b1) begin n_fail++;
        $display("FAIL basic_hs%0d: we=%b wait=%b, required 1/1", i, we_s, wait_s); end
      n_checks++;
      if (a_s !== ADDR_W'(i) || d_s !== exp_d) begin n_fail++;
        $display("FAIL basic_bus%0d: addr=%h data=%h, required addr=%h data=%h", i, a_s, d_s, i, exp_d); end
      n_checks++;
      if (!held || we_a !== 1'b0) begin n_fail++;
        $display("FAIL basic_hold%0d: held=%b we_after_ack=%b, required 1/0", i, held, we_a); end
    end
    n_checks++;
    if (loading !== 1'b1 || sg1000 !== 1'b0) begin n_fail++;
      $display("FAIL basic_flags: loading=%b sg1000=%b, required 1/0", loading, sg1000); end
`ifdef CART_LOADER_CHECKSUM_EN
    n_checks++;
    if (cart_sum !== 16'h01FE) begin n_fail++;
      $display("FAIL basic_sum: cart_sum=%h, required 01fe", cart_sum); end
`endif
    end_download(seen, cyc);
    n_checks++;
    if (!seen || cyc != 1 || done_cnt - d0 != 1) begin n_fail++;
      $display("FAIL basic_done: seen=%b cycles=%0d pulses=%0d, required 1/1/1", seen, cyc, done_cnt - d0); end
    n_checks++;
    if (cart_pages !== '0 || loading !== 1'b0) begin n_fail++;
      $display("FAIL basic_end: pages=%0d loading=%b, required 0/0", cart_pages, loading); end
  endtask

  task automatic test_busy_wr();
    int w0, cyc;
    logic seen;
    quick_write(25'h0, 8'h01);
    w0 = we_cnt;
    bus.ioctl_addr = 25'h10; bus.ioctl_dout = 8'h11; bus.ioctl_wr = 1'b1;
    @(negedge clk_sys);
    bus.ioctl_addr = 25'h20; bus.ioctl_dout = 8'h22;
    @(negedge clk_sys);
    bus.ioctl_wr = 1'b0;
    n_checks++;
    if (bus.mem_addr !== 20'h10 || bus.mem_data !== 8'h11 || bus.mem_we !== 1'b1) begin n_fail++;
      $display("FAIL busy_hold: addr=%h data=%h we=%b, required 10/11/1", bus.mem_addr, bus.mem_data, bus.mem_we); end
    bus.mem_ack = 1'b1;
    @(negedge clk_sys);
    bus.mem_ack = 1'b0;
    @(negedge clk_sys);
    n_checks++;
    if (bus.mem_we !== 1'b0 || we_cnt - w0 != 1) begin n_fail++;
      $display("FAIL busy_ignored: we=%b writes=%0d, required 0 and 1", bus.mem_we, we_cnt - w0); end
    end_download(seen, cyc);
  endtask

  task automatic test_pages();
    int cyc;
    logic seen;
    bus.ioctl_index = 8'h00;
    quick_write(25'h0, 8'h00);
    quick_write(25'h1C000, 8'h12);
    n_checks++;
    if (cart_pages !== 6'd7) begin n_fail++;
      $display("FAIL pages_high: cart_pages=%0d, required 7", cart_pages); end
    quick_write(25'h04000, 8'h34);
    n_checks++;
    if (cart_pages !== 6'd7) begin n_fail++;
      $display("FAIL pages_keep: cart_pages=%0d, required 7", cart_pages); end
    end_download(seen, cyc);
  endtask

  task automatic test_overflow();
    int cyc;
    logic seen;
    quick_write(25'h0, 8'h00);
    bus.ioctl_addr = 25'h100000; bus.ioctl_dout = 8'h55; bus.ioctl_wr = 1'b1;
    @(negedge clk_sys);
    bus.ioctl_wr = 1'b0;
    n_checks++;
    if (bus.mem_we !== 1'b0 || bus.ioctl_wait !== 1'b0 || overflow !== 1'b1) begin n_fail++;
      $display("FAIL ovf_drop: we=%b wait=%b ovf=%b, required 0/0/1", bus.mem_we, bus.ioctl_wait, overflow); end
    @(negedge clk_sys);
    n_checks++;
    if (bus.mem_we !== 1'b0 || overflow !== 1'b1) begin n_fail++;
      $display("FAIL ovf_sticky: we=%b ovf=%b, required 0/1", bus.mem_we, overflow); end
    quick_write(25'hFFFFF, 8'hEE);
    n_checks++;
    if (bus.mem_addr !== 20'hFFFFF || cart_pages !== 6'd63) begin n_fail++;
      $display("FAIL ovf_top: addr=%h pages=%0d, required fffff/63", bus.mem_addr, cart_pages); end
    quick_write(25'h0, 8'h00);
    n_checks++;
    if (overflow !== 1'b0 || cart_pages !== '0) begin n_fail++;
      $display("FAIL ovf_clear: ovf=%b pages=%0d, required 0/0", overflow, cart_pages); end
    end_download(seen, cyc);
  endtask

  task automatic test_sg1000();
    int cyc;
    logic seen;
    bus.ioctl_index = 8'h02;
    quick_write(25'h0, 8'h00);
    n_checks++;
    if (sg1000 !== 1'b1 || extram !== 1'b0) begin n_fail++;
      $display("FAIL sg_start: sg1000=%b extram=%b, required 1/0", sg1000, extram); end
    quick_write(25'h2000, 8'hFF);
    n_checks++;
    if (extram !== 1'b1) begin n_fail++; $display("FAIL sg_first: extram=%b, required 1", extram); end
    for (int a = 'h2001; a <= 'h3FFF; a++) quick_write(25'(a), 8'hFF);
    quick_write(25'h4000, 8'h00);
    n_checks++;
    if (extram !== 1'b1 || cart_pages !== 6'd1) begin n_fail++;
      $display("FAIL sg_full: extram=%b pages=%0d, required 1/1", extram, cart_pages); end
    end_download(seen, cyc);
    quick_write(25'h0, 8'h00);
    n_checks++;
    if (extram !== 1'b0 || cart_pages !== '0) begin n_fail++;
      $display("FAIL sg_restart: extram=%b pages=%0d, required 0/0", extram, cart_pages); end
    for (int a = 'h2000; a <= 'h2FFF; a++) quick_write(25'(a), 8'hFF);
    quick_write(25'h3000, 8'h00);
    quick_write(25'h3001, 8'hFF);
    n_checks++;
    if (extram !== 1'b0 || sg1000 !== 1'b1) begin n_fail++;
      $display("FAIL sg_hole: extram=%b sg1000=%b, required 0/1", extram, sg1000); end
    end_download(seen, cyc);
    bus.ioctl_index = 8'h00;
  endtask

  task automatic test_fall_during_wait();
    int d0;
    d0 = done_cnt;
    bus.ioctl_download = 1'b1; bus.ioctl_addr = 25'h0; bus.ioctl_dout = 8'h77; bus.ioctl_wr = 1'b1;
    @(negedge clk_sys);
    bus.ioctl_wr = 1'b0;
    @(negedge clk_sys);
    bus.ioctl_download = 1'b0;
    repeat (5) @(negedge clk_sys);
    n_checks++;
    if (bus.mem_we !== 1'b1 || bus.mem_data !== 8'h77 || load_done !== 1'b0) begin n_fail++;
      $display("FAIL fall_pending: we=%b data=%h done=%b, required 1/77/0", bus.mem_we, bus.mem_data, load_done); end
    bus.mem_ack = 1'b1;
    @(negedge clk_sys);
    bus.mem_ack = 1'b0;
    n_checks++;
    if (load_done !== 1'b1 || bus.mem_we !== 1'b0 || bus.ioctl_wait !== 1'b0) begin n_fail++;
      $display("FAIL fall_done: done=%b we=%b wait=%b, required 1/0/0", load_done, bus.mem_we, bus.ioctl_wait); end
    @(negedge clk_sys);
    n_checks++;
    if (load_done !== 1'b0 || done_cnt - d0 != 1) begin n_fail++;
      $display("FAIL fall_once: done=%b pulses=%0d, required 0/1", load_done, done_cnt - d0); end
    bus.ioctl_download = 1'b1; bus.ioctl_addr = 25'h0; bus.ioctl_dout = 8'h10; bus.ioctl_wr = 1'b1;
    @(negedge clk_sys);
    bus.ioctl_wr = 1'b0; bus.mem_ack = 1'b1; bus.ioctl_download = 1'b0;
    @(negedge clk_sys);
    bus.mem_ack = 1'b0;
    n_checks++;
    if (load_done !== 1'b1 || bus.mem_we !== 1'b0) begin n_fail++;
      $display("FAIL fall_with_ack: done=%b we=%b, required 1/0", load_done, bus.mem_we); end
    repeat (2) @(negedge clk_sys);
  endtask

  task automatic test_reset_mid_write();
    int d0;
    quick_write(25'h0, 8'hFF);
    quick_write(25'h1, 8'h02);
`ifdef CART_LOADER_CHECKSUM_EN
    n_checks++;
    if (cart_sum !== 16'h0101) begin n_fail++;
      $display("FAIL rst_sum: cart_sum=%h, required 0101", cart_sum); end
`endif
    d0 = done_cnt;
    bus.ioctl_addr = 25'h2; bus.ioctl_dout = 8'h33; bus.ioctl_wr = 1'b1;
    @(negedge clk_sys);
    bus.ioctl_wr = 1'b0;
    @(negedge clk_sys);
    n_checks++;
    if (bus.mem_we !== 1'b1) begin n_fail++; $display("FAIL rst_pre: we=%b, required 1", bus.mem_we); end
    reset = 1'b1; bus.ioctl_download = 1'b0;
    @(negedge clk_sys);
    reset = 1'b0;
    n_checks++;
    if (bus.mem_we !== 1'b0 || bus.ioctl_wait !== 1'b0 || loading !== 1'b0) begin n_fail++;
      $display("FAIL rst_drop: we=%b wait=%b loading=%b, required 0/0/0", bus.mem_we, bus.ioctl_wait, loading); end
    repeat (5) @(negedge clk_sys);
    n_checks++;
    if (done_cnt != d0 || bus.mem_we !== 1'b0 || bus.mem_addr !== '0) begin n_fail++;
      $display("FAIL rst_quiet: pulses=%0d we=%b addr=%h, required 0/0/0", done_cnt - d0, bus.mem_we, bus.mem_addr); end
`ifdef CART_LOADER_CHECKSUM_EN
    n_checks++;
    if (cart_sum !== 16'h0000) begin n_fail++;
      $display("FAIL rst_sum_clear: cart_sum=%h, required 0000", cart_sum); end
`endif
  endtask

  initial begin
    test_reset();
    test_empty_download();
    test_basic_load();
    test_busy_wr();
    test_pages();
    test_overflow();
    test_sg1000();
    test_fall_during_wait();
    test_reset_mid_write();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
